i2s_frame_fifo: RTL

Receive-side frame buffer sitting directly downstream of the I2S controller that drives the Pmod I2S2 (CS5343 ADC). It captures each stereo frame the controller delivers once per LRCK period on a single-cycle strobe, stores it in a small FIFO, and presents frames to the downstream processing logic over a valid/ready handshake. The I2S side cannot be stalled, so the block absorbs consumer jitter and reports lost frames with a sticky overflow flag.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_frame_mem.sv | 30 +++
 rtl/i2s_frame_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S receive-path types: sample width and the stereo frame layout
// used by the controller, the frame FIFO and the DSP consumer.
package i2s_pkg;

   localparam int SAMPLE_W = 24;
   localparam int FRAME_W  = 2 * SAMPLE_W;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } frame_t;

endpackage

// File: rtl/i2s_frame_mem.sv
// Frame storage for the I2S frame FIFO: register array with one synchronous
// write port and one asynchronous read port.
module i2s_frame_mem #(
   parameter int DEPTH   = 4,
   parameter int FRAME_W = 48
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [FRAME_W-1:0]       wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [FRAME_W-1:0]       rd_data
);

   logic [FRAME_W-1:0] mem [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == gi[$clog2(DEPTH)-1:0])) begin
               mem[gi] <= wr_data;
            end
         end
      end
   endgenerate

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2s_frame_fifo.sv
// Receive-side stereo frame FIFO: captures one frame per strobe, presents the
// head frame first-word-fall-through on registered outputs, flags lost frames.
module i2s_frame_fifo #(
   parameter int SAMPLE_W = i2s_pkg::SAMPLE_W,
   parameter int DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SAMPLE_W-1:0]        inLeft,
   input  logic [SAMPLE_W-1:0]        inRight,
   input  logic                       inStrobe,
   output logic [SAMPLE_W-1:0]        outLeft,
   output logic [SAMPLE_W-1:0]        outRight,
   output logic                       outValid,
   input  logic                       outReady,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clearOverflow
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LW      = AW + 1;
   localparam int FRAME_W = 2 * SAMPLE_W;

   logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
   logic [LW-1:0]       level_reg, level_next, level_after_pop;
   logic                valid_reg;
   logic                overflow_reg, overflow_next;
   logic [FRAME_W-1:0]  out_frame_reg, out_frame_next;
   logic [FRAME_W-1:0]  in_frame, rd_data;
   logic                push, pop, full, drop, bypass;

   assign in_frame = {inLeft, inRight};

   always_comb begin
      pop             = valid_reg && outReady;
      full            = (level_reg == LW'(DEPTH));
      push            = inStrobe && (!full || pop);
      drop            = inStrobe && full && !pop;
      level_after_pop = level_reg - LW'(pop);
      level_next      = level_after_pop + LW'(push);
      wr_ptr_next     = wr_ptr_reg + AW'(push);
      rd_ptr_next     = rd_ptr_reg + AW'(pop);
      // The new head is the frame being written right now only when nothing
      // else remains stored after this cycle's pop.
      bypass          = push && (level_after_pop == '0);
      out_frame_next  = out_frame_reg;
      if (level_next != '0) begin
         out_frame_next = bypass ? in_frame : rd_data;
      end
      overflow_next = overflow_reg;
      if (drop) begin
         overflow_next = 1'b1;
      end else if (clearOverflow) begin
         overflow_next = 1'b0;
      end
   end

   i2s_frame_mem #(
      .DEPTH   (DEPTH),
      .FRAME_W (FRAME_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_reg),
      .wr_data (in_frame),
      .rd_addr (rd_ptr_next),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         valid_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
         out_frame_reg <= '0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         level_reg     <= level_next;
         valid_reg     <= (level_next != '0);
         overflow_reg  <= overflow_next;
         out_frame_reg <= out_frame_next;
      end
   end

   assign outLeft  = out_frame_reg[FRAME_W-1:SAMPLE_W];
   assign outRight = out_frame_reg[SAMPLE_W-1:0];
   assign outValid = valid_reg;
   assign level    = level_reg;
   assign overflow = overflow_reg;

endmodule
